// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA key-and-cipher engine.
package rsa_pkg;

  localparam int          RSA_DEFAULT_WIDTH = 32;
  localparam int unsigned RSA_DEFAULT_E     = 32'd65537;

  typedef enum logic [2:0] {
    IDLE,
    INV_MUL,
    INV_DIV,
    INV_UPD,
    INV_DONE,
    EXP_SQ,
    EXP_MUL,
    EXP_DONE
  } rsa_state_e;

  // Message, modulus and exponent words are twice the prime width.
  function automatic int rsa_word_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/rsa_control_if.sv
// Host-side bus of rsa_control. RSA_CONTROL_KEY_OUT_EN adds priv_key/modulus.
interface rsa_control_if #(
  parameter int WIDTH = 32
);
  localparam int W2 = 2 * WIDTH;

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] q;
  logic             reset_inverter;
  logic             reset_mod_exp;
  logic             encrypt_decrypt;
  logic [W2-1:0]    msg_in;
  logic             inverter_finish;
  logic [W2-1:0]    msg_out;
  logic             mod_exp_finish;
`ifdef RSA_CONTROL_KEY_OUT_EN
  logic [W2-1:0]    priv_key;
  logic [W2-1:0]    modulus;

  modport master (
    output p, q, reset_inverter, reset_mod_exp, encrypt_decrypt, msg_in,
    input  inverter_finish, msg_out, mod_exp_finish, priv_key, modulus
  );
  modport slave (
    input  p, q, reset_inverter, reset_mod_exp, encrypt_decrypt, msg_in,
    output inverter_finish, msg_out, mod_exp_finish, priv_key, modulus
  );
`else
  modport master (
    output p, q, reset_inverter, reset_mod_exp, encrypt_decrypt, msg_in,
    input  inverter_finish, msg_out, mod_exp_finish
  );
  modport slave (
    input  p, q, reset_inverter, reset_mod_exp, encrypt_decrypt, msg_in,
    output inverter_finish, msg_out, mod_exp_finish
  );
`endif
endinterface

// File: rtl/rsa_mod_mul.sv
// Sequential (a*b) mod m, MSB-first interleaved shift-add, W+2 cycles
// from start to done. Requires b < m. A start while busy restarts it.
module rsa_mod_mul #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_start,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_m,
  output logic         o_done,
  output logic [W-1:0] o_result
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  r_a, r_b, r_m, r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_busy, r_done;
  logic [W:0]    w_dbl, w_sum;
  logic [W-1:0]  w_dbl_red, w_sum_red;

  // One Horner step: acc = 2*acc + a_msb*b, each partial reduced below m.
  always_comb begin
    w_dbl     = {r_acc, 1'b0};
    w_dbl_red = W'((w_dbl >= {1'b0, r_m}) ? w_dbl - {1'b0, r_m} : w_dbl);
    w_sum     = {1'b0, w_dbl_red} + (r_a[W-1] ? {1'b0, r_b} : '0);
    w_sum_red = W'((w_sum >= {1'b0, r_m}) ? w_sum - {1'b0, r_m} : w_sum);
  end

  // Operand capture, iteration counter and single-cycle done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_m    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (i_start) begin
      r_a    <= i_a;
      r_b    <= i_b;
      r_m    <= i_m;
      r_acc  <= '0;
      r_cnt  <= CW'(W);
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (r_busy) begin
      r_acc <= w_sum_red;
      r_a   <= r_a << 1;
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_done   = r_done;
  assign o_result = r_acc;

endmodule

// File: rtl/rsa_control.sv
// RSA key derivation (n, d) and modular exponentiation for one key pair.
// Optional build macro RSA_CONTROL_KEY_OUT_EN exposes d and n on the bus.
module rsa_control
  import rsa_pkg::*;
#(
  parameter int          WIDTH = RSA_DEFAULT_WIDTH,
  parameter int unsigned E     = RSA_DEFAULT_E
) (
  input  logic         clk,
  input  logic         reset_n,
  rsa_control_if.slave bus
);
  localparam int            W2  = rsa_word_w(WIDTH);
  localparam int            CW  = $clog2(W2 + 1);
  localparam logic [W2-1:0] E_W = W2'(E);

  // Signed Bezout coefficients; magnitudes stay below 2*phi.
  typedef logic signed [W2+1:0] sword_t;

  rsa_state_e r_state, w_next;

  logic [W2-1:0]    r_ma, r_ma1, r_nacc, r_phi;
  logic [WIDTH-1:0] r_mb, r_mb1;
  logic [W2-1:0]    r_r0, r_r1, r_rem;
  sword_t           r_t0, r_t1, r_prod;
  logic [CW-1:0]    r_cnt;
  logic [W2-1:0]    r_n, r_d;
  logic [W2-1:0]    r_base, r_res, r_k, r_msg_out;
  logic             r_wait, r_inv_fin, r_exp_fin;

  logic             w_str_inv, w_str_exp;
  logic [W2:0]      w_rem_sh;
  logic             w_ge;
  logic [W2-1:0]    w_rem_nxt, w_d_pos;
  logic             w_mm_start, w_mm_done;
  logic [W2-1:0]    w_mm_a, w_mm_res;

  // Key-derivation strobe has priority over the exponentiation strobe.
  assign w_str_inv = bus.reset_inverter;
  assign w_str_exp = bus.reset_mod_exp & ~bus.reset_inverter;

  // Restoring-divider step on r0/r1 and final d normalisation into [0, phi).
  always_comb begin
    w_rem_sh  = {r_rem, r_r0[W2-1]};
    w_ge      = (w_rem_sh >= {1'b0, r_r1});
    w_rem_nxt = W2'(w_ge ? w_rem_sh - {1'b0, r_r1} : w_rem_sh);
    w_d_pos   = r_t0[W2+1] ? r_t0[W2-1:0] + r_phi : r_t0[W2-1:0];
  end

  assign w_mm_a = (r_state == EXP_MUL) ? r_res : r_base;

  rsa_mod_mul #(.W(W2)) u_mod_mul (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_start  (w_mm_start),
    .i_a      (w_mm_a),
    .i_b      (r_base),
    .i_m      (r_n),
    .o_done   (w_mm_done),
    .o_result (w_mm_res)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next state and multiplier start; strobes abort any running operation.
  always_comb begin
    w_next     = r_state;
    w_mm_start = 1'b0;
    if (w_str_inv) begin
      w_next = INV_MUL;
    end else if (w_str_exp) begin
      w_next = EXP_MUL;
    end else begin
      case (r_state)
        INV_MUL:  if (r_cnt == '0) w_next = INV_DIV;
        INV_DIV:  if (r_cnt == CW'(1)) w_next = INV_UPD;
        INV_UPD:  w_next = (r_rem == '0) ? INV_DONE : INV_DIV;
        INV_DONE: w_next = IDLE;
        EXP_MUL: begin
          if (!r_k[0])        w_next = EXP_SQ;
          else if (!r_wait)   w_mm_start = 1'b1;
          else if (w_mm_done) w_next = EXP_SQ;
        end
        EXP_SQ: begin
          if (!r_wait)        w_mm_start = 1'b1;
          else if (w_mm_done) w_next = (r_cnt == CW'(1)) ? EXP_DONE : EXP_MUL;
        end
        EXP_DONE: w_next = IDLE;
        default:  w_next = IDLE;
      endcase
    end
  end

  // Datapath: products, extended Euclid, square-and-multiply, result flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ma      <= '0;
      r_ma1     <= '0;
      r_mb      <= '0;
      r_mb1     <= '0;
      r_nacc    <= '0;
      r_phi     <= '0;
      r_r0      <= '0;
      r_r1      <= '0;
      r_rem     <= '0;
      r_t0      <= '0;
      r_t1      <= '0;
      r_prod    <= '0;
      r_cnt     <= '0;
      r_n       <= '0;
      r_d       <= '0;
      r_base    <= '0;
      r_res     <= '0;
      r_k       <= '0;
      r_msg_out <= '0;
      r_wait    <= 1'b0;
      r_inv_fin <= 1'b0;
      r_exp_fin <= 1'b0;
    end else if (w_str_inv) begin
      r_inv_fin <= 1'b0;
      r_ma      <= W2'(bus.p);
      r_ma1     <= W2'(bus.p - WIDTH'(1));
      r_mb      <= bus.q;
      r_mb1     <= bus.q - WIDTH'(1);
      r_nacc    <= '0;
      r_phi     <= '0;
      r_cnt     <= CW'(WIDTH);
      r_wait    <= 1'b0;
    end else if (w_str_exp) begin
      r_exp_fin <= 1'b0;
      r_base    <= bus.msg_in;
      r_res     <= W2'(1);
      r_k       <= bus.encrypt_decrypt ? r_d : E_W;
      r_cnt     <= CW'(W2);
      r_wait    <= 1'b0;
    end else begin
      case (r_state)
        INV_MUL: begin
          if (r_cnt == '0) begin
            // Euclid on (phi, E): r = phi*s + E*t, only t is tracked.
            r_r0   <= r_phi;
            r_r1   <= E_W;
            r_t0   <= '0;
            r_t1   <= sword_t'(1);
            r_rem  <= '0;
            r_prod <= '0;
            r_cnt  <= CW'(W2);
          end else begin
            if (r_mb[0])  r_nacc <= r_nacc + r_ma;
            if (r_mb1[0]) r_phi  <= r_phi + r_ma1;
            r_ma  <= r_ma << 1;
            r_ma1 <= r_ma1 << 1;
            r_mb  <= r_mb >> 1;
            r_mb1 <= r_mb1 >> 1;
            r_cnt <= r_cnt - CW'(1);
          end
        end
        INV_DIV: begin
          // Quotient bits arrive MSB first, so quotient*t1 builds by Horner.
          r_rem  <= w_rem_nxt;
          r_r0   <= r_r0 << 1;
          r_prod <= (r_prod <<< 1) + (w_ge ? r_t1 : '0);
          r_cnt  <= r_cnt - CW'(1);
        end
        INV_UPD: begin
          r_r0   <= r_r1;
          r_r1   <= r_rem;
          r_t0   <= r_t1;
          r_t1   <= r_t0 - r_prod;
          r_rem  <= '0;
          r_prod <= '0;
          r_cnt  <= CW'(W2);
        end
        INV_DONE: begin
          // r0 now holds gcd(phi, E) and t0 its E coefficient.
          r_n       <= r_nacc;
          r_d       <= (r_r0 == W2'(1)) ? w_d_pos : '0;
          r_inv_fin <= 1'b1;
        end
        EXP_MUL: begin
          if (r_k[0]) begin
            if (!r_wait) begin
              r_wait <= 1'b1;
            end else if (w_mm_done) begin
              r_res  <= w_mm_res;
              r_wait <= 1'b0;
            end
          end
        end
        EXP_SQ: begin
          if (!r_wait) begin
            r_wait <= 1'b1;
          end else if (w_mm_done) begin
            r_base <= w_mm_res;
            r_wait <= 1'b0;
            r_k    <= r_k >> 1;
            r_cnt  <= r_cnt - CW'(1);
          end
        end
        EXP_DONE: begin
          // No key yet (n=0) yields 0 rather than the unreduced accumulator.
          r_msg_out <= (r_n == '0) ? '0 : r_res;
          r_exp_fin <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.inverter_finish = r_inv_fin;
  assign bus.mod_exp_finish  = r_exp_fin;
  assign bus.msg_out         = r_msg_out;
`ifdef RSA_CONTROL_KEY_OUT_EN
  assign bus.priv_key        = r_d;
  assign bus.modulus         = r_n;
`endif

endmodule

// File: tb/tb_rsa_control.sv
// Directed bench for rsa_control at WIDTH=8 (16-bit words).
module tb_rsa_control;
  localparam int WIDTH = 8;
  localparam int W2    = 16;
  localparam int BUDGET = 3000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rsa_control_if #(.WIDTH(WIDTH)) ifa ();
  rsa_control_if #(.WIDTH(WIDTH)) ifb ();

  rsa_control #(.WIDTH(WIDTH), .E(17)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));
  rsa_control #(.WIDTH(WIDTH), .E(3))  dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic          enc;
    logic [W2-1:0] msg;
    logic [W2-1:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [W2-1:0] act, input logic [W2-1:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  function automatic logic get_fin(input bit sel, input bit inv);
    if (sel) return inv ? ifb.inverter_finish : ifb.mod_exp_finish;
    return inv ? ifa.inverter_finish : ifa.mod_exp_finish;
  endfunction

  function automatic logic [W2-1:0] get_out(input bit sel);
    return sel ? ifb.msg_out : ifa.msg_out;
  endfunction

  task automatic drive(input bit sel, input bit inv, input bit ex, input logic [WIDTH-1:0] pp,
                       input logic [WIDTH-1:0] qq, input logic enc, input logic [W2-1:0] msg);
    @(negedge clk);
    if (sel) begin
      ifb.p = pp; ifb.q = qq; ifb.reset_inverter = inv; ifb.reset_mod_exp = ex;
      ifb.encrypt_decrypt = enc; ifb.msg_in = msg;
    end else begin
      ifa.p = pp; ifa.q = qq; ifa.reset_inverter = inv; ifa.reset_mod_exp = ex;
      ifa.encrypt_decrypt = enc; ifa.msg_in = msg;
    end
    @(negedge clk);
    if (sel) begin ifb.reset_inverter = 1'b0; ifb.reset_mod_exp = 1'b0; end
    else     begin ifa.reset_inverter = 1'b0; ifa.reset_mod_exp = 1'b0; end
  endtask

  task automatic wait_done(input bit sel, input bit inv, input string name);
    int i = 0;
    while (!get_fin(sel, inv) && i < BUDGET) begin
      @(negedge clk);
      i++;
    end
    check(name, W2'(get_fin(sel, inv)), W2'(1));
  endtask

  task automatic derive(input bit sel, input logic [WIDTH-1:0] pp, input logic [WIDTH-1:0] qq, input string name);
    drive(sel, 1'b1, 1'b0, pp, qq, 1'b0, '0);
    check({name, " inv_fin drop"}, W2'(get_fin(sel, 1'b1)), '0);
    wait_done(sel, 1'b1, {name, " inv_fin"});
  endtask

  task automatic run_exp(input bit sel, input logic enc, input logic [W2-1:0] msg,
                         input logic [W2-1:0] expv, input string name);
    drive(sel, 1'b0, 1'b1, '0, '0, enc, msg);
    check({name, " exp_fin drop"}, W2'(get_fin(sel, 1'b0)), '0);
    wait_done(sel, 1'b0, {name, " exp_fin"});
    check(name, get_out(sel), expv);
  endtask

  initial begin
    vec_t vecs[10];
    vecs[0] = '{1'b0, 16'd65,   16'd2790};
    vecs[1] = '{1'b1, 16'd2790, 16'd65};
    vecs[2] = '{1'b0, 16'd2,    16'd1752};
    vecs[3] = '{1'b1, 16'd1752, 16'd2};
    vecs[4] = '{1'b0, 16'd0,    16'd0};
    vecs[5] = '{1'b1, 16'd0,    16'd0};
    vecs[6] = '{1'b0, 16'd1,    16'd1};
    vecs[7] = '{1'b1, 16'd1,    16'd1};
    vecs[8] = '{1'b0, 16'd3232, 16'd3232};
    vecs[9] = '{1'b1, 16'd3232, 16'd3232};

    ifa.p = '0; ifa.q = '0; ifa.reset_inverter = 1'b0; ifa.reset_mod_exp = 1'b0;
    ifa.encrypt_decrypt = 1'b0; ifa.msg_in = '0;
    ifb.p = '0; ifb.q = '0; ifb.reset_inverter = 1'b0; ifb.reset_mod_exp = 1'b0;
    ifb.encrypt_decrypt = 1'b0; ifb.msg_in = '0;

    repeat (3) @(negedge clk);
    check("reset msg_out",  ifa.msg_out, '0);
    check("reset inv_fin",  W2'(ifa.inverter_finish), '0);
    check("reset exp_fin",  W2'(ifa.mod_exp_finish), '0);
    reset_n = 1'b1;

    // Exponentiation with no key yet: n=0 gives 0.
    run_exp(1'b0, 1'b0, 16'd5, 16'd0, "no-key encrypt");

    derive(1'b0, 8'd61, 8'd53, "derive 61x53");
`ifdef RSA_CONTROL_KEY_OUT_EN
    check("priv_key", ifa.priv_key, 16'd2753);
    check("modulus",  ifa.modulus,  16'd3233);
`endif

    foreach (vecs[i])
      run_exp(1'b0, vecs[i].enc, vecs[i].msg, vecs[i].exp, $sformatf("vec%0d", i));

    // Restart mid-exponentiation: old result held until the new one lands.
    drive(1'b0, 1'b0, 1'b1, '0, '0, 1'b0, 16'd65);
    check("restart exp_fin drop", W2'(ifa.mod_exp_finish), '0);
    repeat (40) @(negedge clk);
    check("restart msg_out held", ifa.msg_out, 16'd3232);
    drive(1'b0, 1'b0, 1'b1, '0, '0, 1'b0, 16'd2);
    check("restart exp_fin low", W2'(ifa.mod_exp_finish), '0);
    wait_done(1'b0, 1'b0, "restart exp_fin");
    check("restart result", ifa.msg_out, 16'd1752);

    // Both strobes together: derivation runs, exponentiation is ignored.
    drive(1'b0, 1'b1, 1'b1, 8'd53, 8'd61, 1'b0, 16'd65);
    check("both: exp_fin kept", W2'(ifa.mod_exp_finish), W2'(1));
    check("both: inv_fin drop", W2'(ifa.inverter_finish), '0);
    wait_done(1'b0, 1'b1, "both: inv_fin");
    check("both: msg_out kept", ifa.msg_out, 16'd1752);
    run_exp(1'b0, 1'b0, 16'd65, 16'd2790, "swapped encrypt");
    run_exp(1'b0, 1'b1, 16'd2790, 16'd65, "swapped decrypt");

    // Asynchronous reset in the middle of a derivation.
    drive(1'b0, 1'b1, 1'b0, 8'd61, 8'd53, 1'b0, '0);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset msg_out", ifa.msg_out, '0);
    check("midreset inv_fin", W2'(ifa.inverter_finish), '0);
    check("midreset exp_fin", W2'(ifa.mod_exp_finish), '0);
    @(negedge clk);
    reset_n = 1'b1;
    derive(1'b0, 8'd61, 8'd53, "rederive");
    run_exp(1'b0, 1'b0, 16'd65, 16'd2790, "rederive encrypt");

    // E=3 with phi=72: not coprime, so d=0 and m^0 = 1.
    derive(1'b1, 8'd7, 8'd13, "noncoprime");
`ifdef RSA_CONTROL_KEY_OUT_EN
    check("noncoprime priv_key", ifb.priv_key, '0);
    check("noncoprime modulus",  ifb.modulus,  16'd91);
`endif
    run_exp(1'b1, 1'b0, 16'd2, 16'd8, "noncoprime encrypt");
    run_exp(1'b1, 1'b1, 16'd5, 16'd1, "noncoprime decrypt d=0");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
